// File: rtl/ccff_pkg.sv
// Shared state encoding and CRC-8 constants for the ccff chain loader.
package ccff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        VERIFY,
        DONE
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One MSB-first step of CRC-8 over a single serial bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial bit-in CRC-8 with synchronous clear and enable; crc_next is the value after
// this cycle's update, so the final bit can be compared on the same edge it is absorbed.
module ccff_crc8
    import ccff_pkg::*;
(
    input  logic       prog_clk,
    input  logic       prog_reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc_next
);

    logic [7:0] crc_q;

    always_comb begin
        crc_next = crc_q;
        if (clear) begin
            crc_next = CRC8_INIT;
        end else if (enable) begin
            crc_next = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_next;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words MSB first into a tile's ccff chain, gating prog_clk via ccff_shift_en.
// Define CCFF_CHAIN_LOADER_VERIFY_EN to add a recirculating CRC-8 readback pass after the load.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 24,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int BY_W = $clog2(DATA_W + 1);
    localparam logic [BL_W-1:0] CHAIN_LEN_C = BL_W'(CHAIN_LEN);
    localparam logic [BL_W-1:0] BL_ONE      = BL_W'(1);
    localparam logic [BY_W-1:0] DATA_W_C    = BY_W'(DATA_W);
    localparam logic [BY_W-1:0] BY_ONE      = BY_W'(1);

    state_t            state;
    logic [BL_W-1:0]   bits_left;
    logic [BY_W-1:0]   byte_left;
    logic [BY_W-1:0]   first_len;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_shl;
    logic              head_q;

    assign sreg_shl = sreg << 1;

    // The final word may carry more bits than the chain still needs; its low bits are dropped.
    always_comb begin
        first_len = DATA_W_C;
        if (int'(bits_left) < DATA_W) begin
            first_len = BY_W'(bits_left);
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state         <= IDLE;
            bits_left     <= '0;
            byte_left     <= '0;
            sreg          <= '0;
            head_q        <= 1'b0;
            in_ready      <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        bits_left <= CHAIN_LEN_C;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        state         <= SHIFT;
                        sreg          <= in_data;
                        head_q        <= in_data[DATA_W-1];
                        byte_left     <= first_len;
                        in_ready      <= 1'b0;
                        ccff_shift_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    sreg      <= sreg_shl;
                    head_q    <= sreg_shl[DATA_W-1];
                    bits_left <= bits_left - BL_ONE;
                    byte_left <= byte_left - BY_ONE;
                    if (byte_left == BY_ONE) begin
                        if (bits_left == BL_ONE) begin
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
                            state     <= VERIFY;
                            bits_left <= CHAIN_LEN_C;
`else
                            state         <= DONE;
                            done          <= 1'b1;
                            ccff_shift_en <= 1'b0;
`endif
                        end else begin
                            state         <= FETCH;
                            in_ready      <= 1'b1;
                            ccff_shift_en <= 1'b0;
                        end
                    end
                end
                VERIFY: begin
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
                    bits_left <= bits_left - BL_ONE;
                    if (bits_left == BL_ONE) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        ccff_shift_en <= 1'b0;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    logic [7:0] sent_crc_next;
    logic [7:0] tail_crc_next;
    logic       crc_clear;

    assign crc_clear = (state == IDLE) && start;

    ccff_crc8 u_sent_crc (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .clear      (crc_clear),
        .enable     (state == SHIFT),
        .bit_in     (head_q),
        .crc_next   (sent_crc_next)
    );

    ccff_crc8 u_tail_crc (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .clear      (crc_clear),
        .enable     (state == VERIFY),
        .bit_in     (ccff_tail),
        .crc_next   (tail_crc_next)
    );

    // Recirculating tail into head for exactly CHAIN_LEN shifts leaves the chain as loaded.
    assign ccff_head = (state == VERIFY) ? ccff_tail : head_q;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            verify_err <= 1'b0;
        end else if (state == IDLE && start) begin
            verify_err <= 1'b0;
        end else if (state == VERIFY && bits_left == BL_ONE && sent_crc_next != tail_crc_next) begin
            verify_err <= 1'b1;
        end
    end
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign verify_err  = 1'b0;
`endif

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
Bitstream writer for the configuration-chain protocol used by the routing and logic tiles (ccff_head in, ccff_tail out, shifted on prog_clk).
- Accepts configuration bytes from the host-side loader over a valid/ready stream.
- Serializes exactly CHAIN_LEN bits into the head of a tile's ccff chain.
- Drives a shift-enable that gates the fabric's prog_clk.
- Samples the chain's ccff_tail so the loaded image can be read back and checked.

Parameters:
- CHAIN_LEN, 24, number of ccff stages in the driven chain (e.g. 12 size-2 mux memories x 2 bits); legal range is 1 or more.
- DATA_W, 8, width of host data word.

Ports:
- prog_clk  in  1  configuration clock; all state is on its rising edge.
- prog_reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- in_data  in  DATA_W  host word; shifted MSB first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- ccff_head  out  1  serial bit to chain head; registered.
- ccff_shift_en  out  1  enable for the external prog_clk gate; the chain shifts on a prog_clk edge where this is 1; registered.
- ccff_tail  in  1  serial bit returned from chain tail.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when load (and verify, if built) completes.
- verify_err  out  1  sticky readback-mismatch flag; cleared by the next accepted start.

Behaviour:
- Reset values: in_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, verify_err=0.
  - All counters are cleared and the state returns to IDLE.
  - Reset mid-operation aborts immediately; chain contents are then undefined and the host must restart.
- IDLE:
  - start=1 clears verify_err, loads bits_left=CHAIN_LEN and moves to FETCH next cycle.
  - start is ignored in every other state.
- FETCH:
  - in_ready=1 and ccff_shift_en=0.
  - On in_valid&in_ready the word goes into shift register sreg, byte_left = min(DATA_W, bits_left), and the state moves to SHIFT.
  - in_valid low holds FETCH indefinitely; no spurious shifts occur.
- SHIFT:
  - Each cycle ccff_shift_en=1 and ccff_head=sreg[MSB]; sreg shifts left, and bits_left and byte_left decrement.
  - When byte_left reaches 0: bits_left>0 goes to FETCH; bits_left==0 goes to VERIFY if built, else DONE.
  - Unused low bits of the final word (CHAIN_LEN not a multiple of DATA_W) are discarded.
- Ordering: the first bit shifted ends in the stage nearest ccff_tail; the last bit ends in the stage nearest ccff_head.
- DONE: done=1 for one cycle, busy=1, then IDLE. Back-to-back start is accepted in the following IDLE cycle.
- Total load cycles with no backpressure: 1 (start) + ceil(CHAIN_LEN/DATA_W) fetch cycles + CHAIN_LEN shift cycles + 1 done cycle.
- Counters: bits_left is $clog2(CHAIN_LEN+1) bits; byte_left is $clog2(DATA_W+1) bits. Neither underflows; 0 is the terminal value.

Optional Feature:
Macro: CCFF_CHAIN_LOADER_VERIFY_EN.
- With the macro:
  - During SHIFT, a CRC-8 (poly 0x07, init 0x00) accumulates each ccff_head bit sent.
  - A VERIFY state then runs CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (recirculation), which restores the chain contents.
  - In VERIFY a second CRC-8 accumulates ccff_tail.
  - At the end, unequal CRCs set verify_err, then DONE.
  - This adds CHAIN_LEN cycles.
- Without the macro: no VERIFY state, no CRC logic, verify_err tied 0, and ccff_tail is unused.

Decomposition:
- Package ccff_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, VERIFY, DONE);
  - CRC8_POLY=8'h07 and CRC8_INIT=8'h00.
- One sub-module, ccff_crc8: serial bit-in CRC-8 with clear and enable. It is instantiated twice under the macro.

Test Plan:
- Nominal load (CHAIN_LEN=24, DATA_W=8): start, bytes A5,3C,0F with in_valid always high.
  - ccff_head over the 24 shift cycles = 1010_0101_0011_1100_0000_1111.
  - A behavioural 24-stage chain model holds 0xA53C0F with bit23 at the tail.
  - done pulses once at cycle 1+3+24+1.
- Partial final word (CHAIN_LEN=20): bytes FF,00,B7.
  - Exactly 20 shift_en cycles; last 4 head bits = 1011.
  - Low nibble 7 is never shifted.
- Backpressure: hold in_valid low for 5 cycles before byte 2.
  - in_ready=1 and ccff_shift_en=0 throughout; chain model contents are identical to the nominal case.
- start while busy: pulse start mid-SHIFT.
  - No restart, and the shift count is still 24.
  - A start in the IDLE cycle after done begins a new load.
- Reset mid-SHIFT after 10 bits:
  - All outputs are 0 the same cycle (async) and the state is IDLE.
  - A fresh load then completes correctly.
- Verify (macro on):
  - With a correct chain model: verify_err=0, and chain contents after VERIFY equal the loaded image.
  - Injecting a flipped ccff_tail bit at verify cycle 7: verify_err=1 at done and held until the next start.
